// File: rtl/vga_capture_checker.sv
// Receive-side VGA checker: recovers pixel coordinates from hsync/vsync, verifies
// line/frame timing, emits captured active pixels and a per-frame 16-bit pixel sum.
module vga_capture_checker #(
  parameter int   H_DISP       = 640,
  parameter int   H_SYNC_START = 656,
  parameter int   H_TOTAL      = 800,
  parameter int   V_DISP       = 480,
  parameter int   V_SYNC_START = 513,
  parameter int   V_TOTAL      = 525,
  parameter logic SYNC_ACTIVE  = 1'b1,
  parameter int   RGB_LAG      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic        sync_err
);

  localparam int PIPE_N = (RGB_LAG > 0) ? RGB_LAG : 1;
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_TOT     = 10'(H_TOTAL);
  localparam logic [9:0] LEN_SAT   = 10'(H_TOTAL + 1);
  localparam logic [9:0] H_SS      = 10'(H_SYNC_START);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_TOT     = 10'(V_TOTAL);
  localparam logic [9:0] LINES_SAT = 10'(V_TOTAL + 1);
  localparam logic [9:0] V_SS      = 10'(V_SYNC_START);
  localparam logic [9:0] X_END     = 10'(H_DISP);
  localparam logic [9:0] Y_END     = 10'(V_DISP);
  localparam logic [9:0] X_MAX     = 10'(H_DISP - 1);
  localparam logic [9:0] Y_MAX     = 10'(V_DISP - 1);

  typedef enum logic [1:0] {ST_ACQ_H, ST_ACQ_V, ST_LOCKED} state_t;
  state_t state_reg, state_next;

  logic        hs_prev, vs_prev, h_seen, v_seen, good_line, armed;
  logic [9:0]  cx, cy, len, lines, cx_now, cy_now, lines_now, lag_x, lag_y;
  logic [9:0]  px_pipe [PIPE_N];
  logic [9:0]  py_pipe [PIPE_N];
  logic [15:0] acc;
  logic [15:0] rgb_ext;
  logic        h_edge, v_edge, line_good, line_bad, frame_good, frame_bad;
  logic        violation, locked_now, valid_now, first_px, last_px;

  assign h_edge    = p_tick && (hsync == SYNC_ACTIVE) && (hs_prev != SYNC_ACTIVE);
  assign v_edge    = p_tick && (vsync == SYNC_ACTIVE) && (vs_prev != SYNC_ACTIVE);
  assign line_good = h_edge && h_seen && (len == H_LAST);
  // len == H_TOT on a non-edge tick means this tick is H_TOTAL+1 since the last edge
  assign line_bad  = (h_edge && h_seen && (len != H_LAST)) ||
                     (p_tick && !h_edge && h_seen && (len == H_TOT));
  assign lines_now = lines + {9'd0, h_edge};
  assign frame_good = v_edge && v_seen && (lines_now == V_TOT);
  assign frame_bad  = (v_edge && v_seen && (lines_now != V_TOT)) ||
                      (h_edge && !v_edge && v_seen && (lines == V_TOT));
  assign violation  = line_bad || frame_bad;

  always_comb begin
    cx_now = cx;
    cy_now = cy;
    if (h_edge) begin
      cx_now = H_SS;
    end else if (cx == H_LAST) begin
      cx_now = '0;
      cy_now = (cy == V_LAST) ? '0 : cy + 10'd1;
    end else begin
      cx_now = cx + 10'd1;
    end
    if (v_edge) cy_now = V_SS;
  end

  always_comb begin
    state_next = state_reg;
    if (violation) begin
      state_next = ST_ACQ_H;
    end else begin
      case (state_reg)
        ST_ACQ_H:  if (line_good && good_line) state_next = ST_ACQ_V;
        ST_ACQ_V:  if (frame_good) state_next = ST_LOCKED;
        ST_LOCKED: state_next = ST_LOCKED;
        default:   state_next = ST_ACQ_H;
      endcase
    end
  end

  generate
    if (RGB_LAG == 0) begin : g_nolag
      assign lag_x = cx_now;
      assign lag_y = cy_now;
    end else begin : g_lag
      assign lag_x = px_pipe[RGB_LAG-1];
      assign lag_y = py_pipe[RGB_LAG-1];
    end
  endgenerate

  assign locked_now = (state_next == ST_LOCKED);
  assign valid_now  = p_tick && locked_now && (lag_x < X_END) && (lag_y < Y_END);
  assign first_px   = (lag_x == 10'd0) && (lag_y == 10'd0);
  assign last_px    = (lag_x == X_MAX) && (lag_y == Y_MAX);
  assign rgb_ext    = {4'd0, rgb};
  assign locked     = (state_reg == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_N; i++) begin
        px_pipe[i] <= '0;
        py_pipe[i] <= '0;
      end
    end else if (p_tick) begin
      px_pipe[0] <= cx_now;
      py_pipe[0] <= cy_now;
      for (int i = 1; i < PIPE_N; i++) begin
        px_pipe[i] <= px_pipe[i-1];
        py_pipe[i] <= py_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_ACQ_H;
      // Seeded as "already active" so a sync pulse in progress at release is not taken as an edge
      hs_prev    <= SYNC_ACTIVE;
      vs_prev    <= SYNC_ACTIVE;
      h_seen     <= 1'b0;
      v_seen     <= 1'b0;
      good_line  <= 1'b0;
      armed      <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      len        <= '0;
      lines      <= '0;
      acc        <= '0;
      x          <= '0;
      y          <= '0;
      pix_valid  <= 1'b0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      sync_err   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sync_err   <= violation;
      pix_valid  <= valid_now;
      frame_done <= 1'b0;
      if (p_tick) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
        cx      <= cx_now;
        cy      <= cy_now;
        x       <= lag_x;
        y       <= lag_y;
        pix_rgb <= rgb;
        if (h_edge) begin
          h_seen <= 1'b1;
          len    <= '0;
        end else if (len != LEN_SAT) begin
          len <= len + 10'd1;
        end
        if (v_edge) lines <= '0;
        else if (h_edge && (lines != LINES_SAT)) lines <= lines + 10'd1;
        // A frame measurement must start after the last violation to count
        if (v_edge) v_seen <= 1'b1;
        else if (violation) v_seen <= 1'b0;
      end
      if (violation) good_line <= 1'b0;
      else if ((state_reg == ST_ACQ_H) && line_good) good_line <= !good_line;
      if (!locked_now) begin
        acc   <= '0;
        armed <= 1'b0;
      end else if (valid_now) begin
        if (first_px) begin
          acc   <= rgb_ext;
          armed <= 1'b1;
        end else if (armed) begin
          if (last_px) begin
            frame_sum  <= acc + rgb_ext;
            frame_done <= 1'b1;
            acc        <= '0;
            armed      <= 1'b0;
          end else begin
            acc <= acc + rgb_ext;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_capture_checker.sv
// Directed bench for vga_capture_checker using a reduced raster (28x13 total, 16x8 active)
// so full frames fit in a short run; p_tick = clk/4, rgb lags coordinates by one tick.
module tb_vga_capture_checker;
  localparam int HD = 16, HSS = 20, HT = 28, VD = 8, VSS = 10, VT = 13;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0, rst = 1'b0, p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [11:0] rgb = '0;
  logic [9:0]  x, y;
  logic        pix_valid, frame_done, locked, sync_err;
  logic [11:0] pix_rgb;
  logic [15:0] frame_sum;

  always #5 clk = ~clk;

  vga_capture_checker #(
    .H_DISP(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_DISP(VD), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b1), .RGB_LAG(1)
  ) dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x(x), .y(y), .pix_valid(pix_valid), .pix_rgb(pix_rgb), .frame_done(frame_done),
    .frame_sum(frame_sum), .locked(locked), .sync_err(sync_err)
  );

  int checks = 0, errors = 0;

  // controller model
  int h, v, ph, pv, line_len, frame_no;
  bit pattern = 0, hs_kill = 0, hs_last = 0;
  int tick_no = 0, last_edge_tick = 0, exp_x = 0, exp_y = 0, tick_v = 0, tick_frame = 0;

  // monitor records
  int err_cnt = 0, last_err_tick = 0, fd_cnt = 0, fd_pix = 0, pix_cnt = 0, coord_bad = 0;
  int lock_v = -1, lock_frame = -1;
  logic [15:0] last_sum = '0;
  logic [11:0] pix5 = '0;
  bit locked_d = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hsync  = (!hs_kill && h >= HSS && h < HSS + 4);
    vsync  = (v >= VSS && v < VSS + 2);
    rgb    = pattern ? 12'(ph % 16) : 12'h00F;
    p_tick = 1'b1;
    if (hsync && !hs_last) last_edge_tick = tick_no + 1;
    hs_last = hsync;
    @(posedge clk);
    tick_no++;
    exp_x = ph; exp_y = pv; tick_v = v; tick_frame = frame_no;
    ph = h; pv = v;
    h++;
    if (h == line_len) begin
      h = 0;
      line_len = HT;
      v++;
      if (v == VT) begin
        v = 0;
        frame_no++;
      end
    end
    @(negedge clk);
    p_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int k = 0;
    while (!locked && k < budget) begin tick(); k++; end
    check_eq(tag, 32'(locked), 32'd1);
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int k = 0;
    int start = fd_cnt;
    while (fd_cnt == start && k < budget) begin tick(); k++; end
    check_eq(tag, 32'(fd_cnt - start), 32'd1);
  endtask

  task automatic wait_pos(input int hh, input int vv, input int budget);
    int k = 0;
    while (!(h == hh && v == vv) && k < budget) begin tick(); k++; end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (sync_err) begin err_cnt++; last_err_tick = tick_no; end
      if (pix_valid) begin
        pix_cnt++;
        if (int'(x) != exp_x || int'(y) != exp_y) coord_bad++;
        if (x == 10'd5 && y == 10'd2) pix5 = pix_rgb;
      end
      if (frame_done) begin
        fd_cnt++;
        last_sum = frame_sum;
        fd_pix = pix_cnt;
        pix_cnt = 0;
      end
      if (locked && !locked_d) begin
        lock_v = tick_v;
        lock_frame = tick_frame;
        pix_cnt = 0;
      end
    end
    locked_d = locked;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, f0;
    // reset held with toggling inputs
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      p_tick = 1'($urandom_range(0, 1));
      hsync  = 1'($urandom_range(0, 1));
      vsync  = 1'($urandom_range(0, 1));
      rgb    = 12'($urandom);
    end
    @(negedge clk);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("rst_sync_err", 32'(sync_err), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_frame_sum", 32'(frame_sum), 32'd0);
    check_eq("rst_x", 32'(x), 32'd0);
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;
    h = 0; v = 0; ph = HT - 1; pv = VT - 1; line_len = HT; frame_no = 0;
    rst = 1'b1;

    // nominal lock and first frame sum: 128 * 15 = 0x780
    wait_lock("nom_lock", 3 * FRAME);
    check_eq("nom_lock_frame", 32'(lock_frame), 32'd1);
    check_eq("nom_lock_row", 32'(lock_v), 32'(VSS));
    wait_fd("nom_fd", 2 * FRAME);
    check_eq("nom_sum", 32'(last_sum), 32'h0780);
    check_eq("nom_pix_count", 32'(fd_pix), 32'd128);
    check_eq("nom_coord_bad", 32'(coord_bad), 32'd0);
    check_eq("nom_sync_err", 32'(err_cnt), 32'd0);

    // rgb = x[3:0]: row sum 120, 8 rows -> 0x3C0
    pattern = 1;
    wait_fd("pat_fd", 2 * FRAME);
    check_eq("pat_pix5", 32'(pix5), 32'h005);
    check_eq("pat_sum", 32'(last_sum), 32'h03C0);
    pattern = 0;

    // one short line in the active region
    wait_pos(0, 3, 2 * FRAME);
    line_len = HT - 1;
    e0 = err_cnt; f0 = fd_cnt;
    wait_pos(0, 9, 2 * FRAME);
    check_eq("short_err", 32'(err_cnt - e0), 32'd1);
    check_eq("short_locked", 32'(locked), 32'd0);
    check_eq("short_no_fd", 32'(fd_cnt - f0), 32'd0);
    wait_lock("short_relock", 3 * FRAME);
    check_eq("short_relock_row", 32'(lock_v), 32'(VSS));

    // hsync stops: timeout exactly H_TOTAL+1 ticks after the last edge, single pulse
    wait_pos(0, 0, 2 * FRAME);
    e0 = err_cnt;
    hs_kill = 1;
    run_ticks(60);
    check_eq("hkill_err", 32'(err_cnt - e0), 32'd1);
    check_eq("hkill_gap", 32'(last_err_tick - last_edge_tick), 32'(HT + 1));
    check_eq("hkill_locked", 32'(locked), 32'd0);
    hs_kill = 0;
    wait_lock("hkill_relock", 4 * FRAME);

    // mid-frame reset at pixel (8,4)
    wait_pos(8, 4, 2 * FRAME);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_locked", 32'(locked), 32'd0);
    check_eq("mrst_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("mrst_frame_sum", 32'(frame_sum), 32'd0);
    check_eq("mrst_x", 32'(x), 32'd0);
    check_eq("mrst_y", 32'(y), 32'd0);
    rst = 1'b1;
    f0 = fd_cnt;
    wait_lock("mrst_relock", 4 * FRAME);
    check_eq("mrst_no_early_fd", 32'(fd_cnt - f0), 32'd0);
    wait_fd("mrst_fd", 2 * FRAME);
    check_eq("mrst_sum", 32'(last_sum), 32'h0780);
    check_eq("mrst_pix_count", 32'(fd_pix), 32'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
